// File: rtl/prog_mod_counter.sv
// ---------------------------------------------------------------------------
// prog_mod_counter
//   Programmable up/down modulo counter with a selectable boundary behaviour.
//   The lower bound is fixed at 0 and the upper bound is max_val (inclusive).
//   At a bound the counter wraps, saturates, or stops in a DONE state,
//   depending on mode.
//
// Parameters
//   W       : width of count, data_in and max_val
//   STEP_W  : width of step (must be smaller than W+1)
//
// Ports
//   clk     in   clock; all state changes on the rising edge
//   rst     in   asynchronous reset, active-low
//   en      in   count enable, active-high
//   updown  in   direction: 1 = up, 0 = down
//   load_n  in   synchronous load of data_in, active-low
//   data_in in   load value (W bits)
//   max_val in   inclusive upper bound (W bits)
//   step    in   amount added or subtracted per enabled cycle (STEP_W bits)
//   mode    in   00 wrap, 01 saturate, 10 one-shot, 11 wrap
//   count   out  registered count (W bits)
//   tc      out  registered terminal-count pulse
//   done    out  registered, high while the counter is in the DONE state
// ---------------------------------------------------------------------------
module prog_mod_counter #(
  parameter int W      = 16,
  parameter int STEP_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              updown,
  input  logic              load_n,
  input  logic [W-1:0]      data_in,
  input  logic [W-1:0]      max_val,
  input  logic [STEP_W-1:0] step,
  input  logic [1:0]        mode,
  output logic [W-1:0]      count,
  output logic              tc,
  output logic              done
);

  typedef enum logic {
    RUN  = 1'b0,
    DONE = 1'b1
  } state_t;

  state_t state;

  // The boundary tests use W+1 bits so that count + step never truncates:
  // an up-count that passes max_val (or starts above it) is always caught.
  logic [W:0]   count_ext;
  logic [W:0]   max_ext;
  logic [W:0]   step_ext;
  logic [W:0]   sum_ext;
  logic [W-1:0] diff;
  logic         overflow;
  logic         underflow;
  logic         sat_mode;
  logic         oneshot_mode;
  logic         stepping;

  assign count_ext = {1'b0, count};
  assign max_ext   = {1'b0, max_val};
  assign step_ext  = {{(W + 1 - STEP_W){1'b0}}, step};
  assign sum_ext   = count_ext + step_ext;
  assign diff      = count - step_ext[W-1:0];

  assign overflow  = (sum_ext > max_ext);
  assign underflow = (count_ext < step_ext);

  // Mode 11 falls through to wrap along with 00.
  assign sat_mode     = (mode == 2'b01);
  assign oneshot_mode = (mode == 2'b10);

  // A zero step is treated like a disabled cycle so it can never fire tc.
  assign stepping = en && (step != '0);

  // The reset value depends on direction: an up-counter starts at its lower
  // bound and a down-counter at its upper bound.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= updown ? '0 : max_val;
      tc    <= 1'b0;
      done  <= 1'b0;
      state <= RUN;
    end else if (!load_n) begin
      count <= data_in;
      tc    <= 1'b0;
      done  <= 1'b0;
      state <= RUN;
    end else if (state == DONE || !stepping) begin
      tc <= 1'b0;
    end else if (updown) begin
      if (overflow) begin
        tc <= 1'b1;
        if (sat_mode) begin
          count <= max_val;
        end else if (oneshot_mode) begin
          count <= max_val;
          done  <= 1'b1;
          state <= DONE;
        end else begin
          count <= '0;
        end
      end else begin
        count <= sum_ext[W-1:0];
        tc    <= 1'b0;
      end
    end else begin
      if (underflow) begin
        tc <= 1'b1;
        if (sat_mode) begin
          count <= '0;
        end else if (oneshot_mode) begin
          count <= '0;
          done  <= 1'b1;
          state <= DONE;
        end else begin
          count <= max_val;
        end
      end else begin
        count <= diff;
        tc    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_prog_mod_counter.sv
// ---------------------------------------------------------------------------
// tb_prog_mod_counter
//   Directed self-checking bench for prog_mod_counter with W=8, STEP_W=4.
//   Inputs change 1 time unit after a rising edge; outputs are checked at
//   that same point, well away from the next active edge.
// ---------------------------------------------------------------------------
module tb_prog_mod_counter;

  logic       clk;
  logic       rst;
  logic       en;
  logic       updown;
  logic       load_n;
  logic [7:0] data_in;
  logic [7:0] max_val;
  logic [3:0] step;
  logic [1:0] mode;
  logic [7:0] count;
  logic       tc;
  logic       done;

  int checks = 0;
  int errors = 0;

  prog_mod_counter #(
    .W      (8),
    .STEP_W (4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .updown  (updown),
    .load_n  (load_n),
    .data_in (data_in),
    .max_val (max_val),
    .step    (step),
    .mode    (mode),
    .count   (count),
    .tc      (tc),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic expectState(input string tag, input int c, input int t, input int d);
    checkOutput({tag, ".count"}, int'(count), c);
    checkOutput({tag, ".tc"},    int'(tc),    t);
    checkOutput({tag, ".done"},  int'(done),  d);
  endtask

  // Drive one cycle's worth of inputs, then advance to just after the edge.
  task automatic applyStimulus(input logic e, input logic ud, input logic ld_n,
                               input logic [7:0] din, input logic [7:0] mx,
                               input logic [3:0] st, input logic [1:0] md);
    en      = e;
    updown  = ud;
    load_n  = ld_n;
    data_in = din;
    max_val = mx;
    step    = st;
    mode    = md;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst     = 1'b1;
    en      = 1'b0;
    updown  = 1'b1;
    load_n  = 1'b1;
    data_in = 8'd0;
    max_val = 8'd9;
    step    = 4'd3;
    mode    = 2'b00;

    // Reset with updown=1 forces count to 0.
    #1 rst = 1'b0;
    #1 expectState("reset_up", 0, 0, 0);
    #10 rst = 1'b1;

    // Wrap up: 3, 6, 9, 0 (tc only on the wrap), then 3 again.
    applyStimulus(1, 1, 1, 8'd0, 8'd9, 4'd3, 2'b00);
    expectState("wrap_up1", 3, 0, 0);
    applyStimulus(1, 1, 1, 8'd0, 8'd9, 4'd3, 2'b00);
    expectState("wrap_up2", 6, 0, 0);
    applyStimulus(1, 1, 1, 8'd0, 8'd9, 4'd3, 2'b00);
    expectState("wrap_up3", 9, 0, 0);
    applyStimulus(1, 1, 1, 8'd0, 8'd9, 4'd3, 2'b00);
    expectState("wrap_up4", 0, 1, 0);
    applyStimulus(1, 1, 1, 8'd0, 8'd9, 4'd3, 2'b00);
    expectState("wrap_up5", 3, 0, 0);

    // Saturate down from 6 with step 4: 2, 0, 0, 0 with tc on the last three.
    applyStimulus(0, 0, 0, 8'd6, 8'd100, 4'd4, 2'b01);
    expectState("sat_load", 6, 0, 0);
    applyStimulus(1, 0, 1, 8'd0, 8'd100, 4'd4, 2'b01);
    expectState("sat_dn1", 2, 0, 0);
    applyStimulus(1, 0, 1, 8'd0, 8'd100, 4'd4, 2'b01);
    expectState("sat_dn2", 0, 1, 0);
    applyStimulus(1, 0, 1, 8'd0, 8'd100, 4'd4, 2'b01);
    expectState("sat_dn3", 0, 1, 0);
    applyStimulus(1, 0, 1, 8'd0, 8'd100, 4'd4, 2'b01);
    expectState("sat_dn4", 0, 1, 0);

    // Saturate up: 98 + 4 passes 100, clamps to 100 and stays there.
    applyStimulus(0, 1, 0, 8'd98, 8'd100, 4'd4, 2'b01);
    expectState("satup_load", 98, 0, 0);
    applyStimulus(1, 1, 1, 8'd0, 8'd100, 4'd4, 2'b01);
    expectState("sat_up1", 100, 1, 0);
    applyStimulus(1, 1, 1, 8'd0, 8'd100, 4'd4, 2'b01);
    expectState("sat_up2", 100, 1, 0);

    // Hold: en=0 for three cycles then step=0 for two cycles.
    applyStimulus(0, 1, 0, 8'd42, 8'd100, 4'd4, 2'b00);
    expectState("hold_load", 42, 0, 0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 1, 1, 8'd0, 8'd100, 4'd4, 2'b00);
      expectState("hold_en0", 42, 0, 0);
    end
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1, 1, 1, 8'd0, 8'd100, 4'd0, 2'b00);
      expectState("hold_step0", 42, 0, 0);
    end

    // Wrap down: 5 -> 2 -> underflow to max_val (mode 11 also wraps).
    applyStimulus(0, 0, 0, 8'd5, 8'd100, 4'd3, 2'b11);
    applyStimulus(1, 0, 1, 8'd0, 8'd100, 4'd3, 2'b11);
    expectState("wrap_dn1", 2, 0, 0);
    applyStimulus(1, 0, 1, 8'd0, 8'd100, 4'd3, 2'b11);
    expectState("wrap_dn2", 100, 1, 0);

    // One-shot up: 2, 4, 5 (done), then held while enabled, direction ignored.
    applyStimulus(0, 1, 0, 8'd0, 8'd5, 4'd2, 2'b10);
    expectState("os_load", 0, 0, 0);
    applyStimulus(1, 1, 1, 8'd0, 8'd5, 4'd2, 2'b10);
    expectState("os_up1", 2, 0, 0);
    applyStimulus(1, 1, 1, 8'd0, 8'd5, 4'd2, 2'b10);
    expectState("os_up2", 4, 0, 0);
    applyStimulus(1, 1, 1, 8'd0, 8'd5, 4'd2, 2'b10);
    expectState("os_up3", 5, 1, 1);
    applyStimulus(1, 1, 1, 8'd0, 8'd5, 4'd2, 2'b10);
    expectState("os_held1", 5, 0, 1);
    applyStimulus(1, 0, 1, 8'd0, 8'd5, 4'd2, 2'b00);
    expectState("os_held2", 5, 0, 1);
    applyStimulus(1, 1, 0, 8'd1, 8'd5, 4'd2, 2'b10);
    expectState("os_reload", 1, 0, 0);

    // Load beats enable; the loaded 200 is above max_val so up overflows.
    applyStimulus(1, 1, 0, 8'd200, 8'd100, 4'd2, 2'b00);
    expectState("ld_prio", 200, 0, 0);
    applyStimulus(1, 1, 1, 8'd0, 8'd100, 4'd2, 2'b00);
    expectState("ld_over", 0, 1, 0);

    // Above max_val, down decrements normally.
    applyStimulus(1, 0, 0, 8'd200, 8'd100, 4'd5, 2'b00);
    applyStimulus(1, 0, 1, 8'd0, 8'd100, 4'd5, 2'b00);
    expectState("above_dn", 195, 0, 0);

    // Reach DONE, then assert reset mid-cycle with updown=0, max_val=50.
    applyStimulus(0, 1, 0, 8'd4, 8'd5, 4'd2, 2'b10);
    applyStimulus(1, 1, 1, 8'd0, 8'd5, 4'd2, 2'b10);
    expectState("pre_rst", 5, 1, 1);
    #3;
    updown  = 1'b0;
    max_val = 8'd50;
    rst     = 1'b0;
    #1 expectState("async_rst", 50, 0, 0);

    // Reset overrides a load across an edge.
    load_n  = 1'b0;
    data_in = 8'd7;
    @(posedge clk);
    #1 expectState("rst_over_ld", 50, 0, 0);

    // Release mid-cycle; counting resumes on the first edge.
    #3;
    rst = 1'b1;
    applyStimulus(1, 0, 1, 8'd0, 8'd50, 4'd5, 2'b00);
    expectState("post_rst", 45, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/prog_mod_counter.md
PROG_MOD_COUNTER -- requirements
Module: prog_mod_counter

Interface
REQ-001 SHALL have parameter W, default 16: counter, data_in and max_val width.
REQ-002 SHALL have parameter STEP_W, default 4: step width.
REQ-003 SHALL have port clk  input  1  clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port en  input  1  count enable, active-high.
REQ-006 SHALL have port updown  input  1  direction, 1 = up, 0 = down.
REQ-007 SHALL have port load_n  input  1  synchronous load, active-low.
REQ-008 SHALL have port data_in  input  W  load value.
REQ-009 SHALL have port max_val  input  W  upper bound, inclusive; lower bound fixed at 0.
REQ-010 SHALL have port step  input  STEP_W  increment/decrement per enabled cycle.
REQ-011 SHALL have port mode  input  2  00 wrap, 01 saturate, 10 one-shot, 11 = wrap.
REQ-012 SHALL have port count  output  W  registered count.
REQ-013 SHALL have port tc  output  1  registered terminal-count pulse.
REQ-014 SHALL have port done  output  1  registered, high while in DONE state.

Function
REQ-015 SHALL implement states RUN and DONE; the done output is 1 iff the state is DONE.
REQ-016 SHALL give priority, highest first: rst, load_n, en, hold.
REQ-017 load_n=0: count <= data_in, tc <= 0, state <= RUN (also exits DONE); en ignored.
REQ-018 en=0 or step=0 (no load): count holds, tc <= 0.
REQ-019 Overflow, up: (count + step) > max_val, evaluated in W+1 bits, no truncation.
REQ-020 Underflow, down: count < step.
REQ-021 RUN, en=1, no overflow/underflow: count <= count +/- step, tc <= 0.
REQ-022 Wrap mode overflow: count <= 0, tc <= 1; underflow: count <= max_val, tc <= 1.
REQ-023 Saturate mode overflow: count <= max_val, tc <= 1; underflow: count <= 0, tc <= 1; tc re-asserts on every enabled cycle at the bound.
REQ-024 One-shot mode overflow/underflow: count <= max_val/0 respectively, tc <= 1, state <= DONE.
REQ-025 DONE: count holds, tc <= 0, en/updown/mode ignored; only load_n or rst exits.
REQ-026 count > max_val (after load or max_val change): up treated as overflow per REQ-019; down decrements normally.
REQ-027 updown, mode, step, max_val sampled each edge; a change takes effect on the next rising edge, no pipeline.
REQ-028 Latency: every count/tc/done update visible one clk after the sampling edge.
REQ-029 tc SHALL be high for exactly one cycle per boundary event, never combinational.

Reset
REQ-030 rst=0 SHALL immediately force count = 0 if updown=1, else count = max_val; tc = 0; state RUN, done = 0.
REQ-031 rst SHALL override load and en mid-operation, including in DONE; release resumes counting on the first edge with rst=1.

Verification (W=8, STEP_W=4)
REQ-032 Wrap up: max_val=9, step=3, count=0, en=1 -> 3,6,9,0 with tc=1 only on the cycle count becomes 0.
REQ-033 Saturate down: max_val=100, step=4, load 6 -> 2,0,0,0; tc=1 on each cycle count is written 0, i.e. on the 2nd, 3rd and 4th steps.
REQ-034 One-shot up: max_val=5, step=2, count=0 -> 2,4,5, done=1 and held 5 while en=1; load_n=0 data_in=1 -> count=1, done=0.
REQ-035 Load priority: en=1, load_n=0, data_in=200, max_val=100, up -> count=200; next en cycle -> overflow, wrap to 0, tc=1.
REQ-036 Async reset: assert rst mid-clock with updown=0, max_val=50 -> count=50, tc=0, done=0 before next edge.
REQ-037 Hold: en=0 or step=0 for 5 cycles -> count unchanged, tc=0.
